// File: rtl/ov7670_config_sequencer_if.sv
// Bus between the OV7670 config sequencer and its register-init ROM plus SCCB master.
// The sequencer side is the master modport; the ROM/SCCB side is the slave modport.
interface ov7670_config_sequencer_if #(
    parameter int ROM_ADDR_W = 8
);
    logic [ROM_ADDR_W-1:0] rom_addr;
    logic [15:0]           rom_data;
    logic                  sccb_start;
    logic [7:0]            sccb_reg_addr;
    logic [7:0]            sccb_reg_data;
    logic                  sccb_ready;

    modport master (
        output rom_addr,
        output sccb_start,
        output sccb_reg_addr,
        output sccb_reg_data,
        input  rom_data,
        input  sccb_ready
    );

    modport slave (
        input  rom_addr,
        input  sccb_start,
        input  sccb_reg_addr,
        input  sccb_reg_data,
        output rom_data,
        output sccb_ready
    );
endinterface

// File: rtl/ov7670_config_sequencer.sv
// Walks the OV7670 register-init ROM and issues one SCCB write per entry.
// 16'hFFF0 inserts a settle delay; 16'hFFFF or the last ROM address ends the sequence.
module ov7670_config_sequencer #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int DELAY_MS    = 10,
    parameter int ROM_ADDR_W  = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    ov7670_config_sequencer_if.master        cfg,
    output logic                             busy,
    output logic                             done
);

    localparam int DELAY_CYCLES = CLK_FREQ_HZ / 1000 * DELAY_MS;
    localparam int CNT_W        = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;

    localparam logic [CNT_W-1:0]      CNT_LOAD  = CNT_W'(DELAY_CYCLES - 1);
    localparam logic [CNT_W-1:0]      CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
    localparam logic [ROM_ADDR_W-1:0] ADDR_ZERO = {ROM_ADDR_W{1'b0}};
    localparam logic [ROM_ADDR_W-1:0] ADDR_ONE  = ROM_ADDR_W'(1);
    localparam logic [ROM_ADDR_W-1:0] ADDR_LAST = {ROM_ADDR_W{1'b1}};
    localparam logic [15:0]           ENTRY_END   = 16'hFFFF;
    localparam logic [15:0]           ENTRY_DELAY = 16'hFFF0;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_WAIT_ROM  = 4'd2,
        S_DECODE    = 4'd3,
        S_SEND      = 4'd4,
        S_WAIT_BUSY = 4'd5,
        S_WAIT_DONE = 4'd6,
        S_DELAY     = 4'd7,
        S_DONE      = 4'd8
    } state_e;

    state_e                state_q,      state_d;
    logic [ROM_ADDR_W-1:0] rom_addr_q,   rom_addr_d;
    logic [7:0]            reg_addr_q,   reg_addr_d;
    logic [7:0]            reg_data_q,   reg_data_d;
    logic                  sccb_start_q, sccb_start_d;
    logic                  busy_q,       busy_d;
    logic                  done_q,       done_d;
    logic [CNT_W-1:0]      cnt_q,        cnt_d;

    state_e                adv_state_s;
    logic [ROM_ADDR_W-1:0] adv_addr_s;

    // Advance to the next ROM entry, stopping at the last address instead of wrapping.
    always_comb begin
        adv_state_s = S_FETCH;
        adv_addr_s  = rom_addr_q + ADDR_ONE;
        if (rom_addr_q == ADDR_LAST) begin
            adv_state_s = S_DONE;
            adv_addr_s  = rom_addr_q;
        end else begin
            adv_state_s = S_FETCH;
        end
    end

    // Next-state and output decode for the sequencer FSM.
    always_comb begin
        state_d      = state_q;
        rom_addr_d   = rom_addr_q;
        reg_addr_d   = reg_addr_q;
        reg_data_d   = reg_data_q;
        cnt_d        = cnt_q;
        sccb_start_d = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    rom_addr_d = ADDR_ZERO;
                    state_d    = S_FETCH;
                end else begin
                    state_d    = state_q;
                end
            end
            S_FETCH:    state_d = S_WAIT_ROM;
            S_WAIT_ROM: state_d = S_DECODE;
            S_DECODE: begin
                if (cfg.rom_data == ENTRY_END) begin
                    state_d = S_DONE;
                end else if (cfg.rom_data == ENTRY_DELAY) begin
                    cnt_d   = CNT_LOAD;
                    state_d = S_DELAY;
                end else begin
                    reg_addr_d = cfg.rom_data[15:8];
                    reg_data_d = cfg.rom_data[7:0];
                    state_d    = S_SEND;
                end
            end
            S_SEND: begin
                // The master only accepts a start while it reports idle.
                if (cfg.sccb_ready) begin
                    sccb_start_d = 1'b1;
                    state_d      = S_WAIT_BUSY;
                end else begin
                    state_d      = S_SEND;
                end
            end
            S_WAIT_BUSY: begin
                if (!cfg.sccb_ready) begin
                    state_d = S_WAIT_DONE;
                end else begin
                    state_d = S_WAIT_BUSY;
                end
            end
            S_WAIT_DONE: begin
                if (cfg.sccb_ready) begin
                    state_d    = adv_state_s;
                    rom_addr_d = adv_addr_s;
                end else begin
                    state_d    = S_WAIT_DONE;
                end
            end
            S_DELAY: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d    = adv_state_s;
                    rom_addr_d = adv_addr_s;
                end else begin
                    cnt_d      = cnt_q - CNT_ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d = (state_d == S_DONE);
    end

    // State and registered-output update with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            rom_addr_q   <= ADDR_ZERO;
            reg_addr_q   <= 8'h00;
            reg_data_q   <= 8'h00;
            sccb_start_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cnt_q        <= CNT_ZERO;
        end else begin
            state_q      <= state_d;
            rom_addr_q   <= rom_addr_d;
            reg_addr_q   <= reg_addr_d;
            reg_data_q   <= reg_data_d;
            sccb_start_q <= sccb_start_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            cnt_q        <= cnt_d;
        end
    end

    assign cfg.rom_addr      = rom_addr_q;
    assign cfg.sccb_start    = sccb_start_q;
    assign cfg.sccb_reg_addr = reg_addr_q;
    assign cfg.sccb_reg_data = reg_data_q;
    assign busy              = busy_q;
    assign done              = done_q;

endmodule

// File: tb/tb_ov7670_config_sequencer.sv
// Scoreboard bench: expected SCCB writes are queued when a ROM image is started and
// popped when the DUT pulses sccb_start; a registered ROM and an SCCB model respond.
module tb_ov7670_config_sequencer;

    localparam int DELAY_CYCLES = 5;
    localparam int XFER_CYCLES  = 20;
    // Cycles from ready rising to the next sccb_start: WAIT_DONE sample + fetch/decode + SEND.
    localparam int GAP_WRITE    = 5;
    localparam int GAP_DELAY    = GAP_WRITE + 3 + DELAY_CYCLES;

    typedef struct {
        logic [15:0] wr;
        int          gap;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic busy;
    logic done;
    logic force_low;
    int   busy_cnt;

    logic [15:0] rom_mem [256];
    exp_t        sb_q [$];
    int          chk_cnt  = 0;
    int          pass_cnt = 0;
    int          cyc, rise_cyc, write_cnt;
    logic        ready_prev, start_prev;

    ov7670_config_sequencer_if #(.ROM_ADDR_W(8)) cfg ();

    ov7670_config_sequencer #(
        .CLK_FREQ_HZ (1000),
        .DELAY_MS    (5),
        .ROM_ADDR_W  (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .cfg   (cfg.master),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Registered ROM: data follows the address one edge later.
    always @(posedge clk) cfg.rom_data <= rom_mem[cfg.rom_addr];

    // SCCB master model: drops ready the cycle after start, busy for XFER_CYCLES.
    always @(posedge clk) begin
        if (reset) begin
            cfg.sccb_ready <= 1'b1;
            busy_cnt       <= 0;
        end else if (cfg.sccb_start) begin
            cfg.sccb_ready <= 1'b0;
            busy_cnt       <= XFER_CYCLES;
        end else if (busy_cnt > 1) begin
            busy_cnt       <= busy_cnt - 1;
        end else if (busy_cnt == 1) begin
            busy_cnt       <= 0;
            cfg.sccb_ready <= 1'b1;
        end else begin
            cfg.sccb_ready <= !force_low;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write monitor and scoreboard consumer.
    initial begin
        exp_t e;
        cyc        = 0;
        rise_cyc   = 0;
        write_cnt  = 0;
        ready_prev = 1'b1;
        start_prev = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset !== 1'b1) begin
                if (cfg.sccb_ready && !ready_prev) rise_cyc = cyc;
                if (cfg.sccb_start) begin
                    write_cnt++;
                    check_eq("start_ready", 32'(cfg.sccb_ready), 32'd1);
                    check_eq("start_single", 32'(start_prev), 32'd0);
                    check_eq("sb_pending", 32'(sb_q.size() != 0), 32'd1);
                    if (sb_q.size() != 0) begin
                        e = sb_q.pop_front();
                        check_eq("write", 32'({cfg.sccb_reg_addr, cfg.sccb_reg_data}), 32'(e.wr));
                        if (e.gap >= 0) check_eq("gap", 32'(cyc - rise_cyc), 32'(e.gap));
                    end
                end
            end
            ready_prev = cfg.sccb_ready;
            start_prev = cfg.sccb_start;
        end
    end

    task automatic rom_clear();
        for (int i = 0; i < 256; i++) rom_mem[i] = 16'hFFFF;
    endtask

    task automatic push(input logic [15:0] wr, input int gap);
        exp_t e;
        e.wr  = wr;
        e.gap = gap;
        sb_q.push_back(e);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, 32'(done), 32'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_addr"},  32'(cfg.rom_addr), 32'd0);
        check_eq({tag, "_start"}, 32'(cfg.sccb_start), 32'd0);
        check_eq({tag, "_reg"},   32'({cfg.sccb_reg_addr, cfg.sccb_reg_data}), 32'd0);
        check_eq({tag, "_busy"},  32'(busy), 32'd0);
        check_eq({tag, "_done"},  32'(done), 32'd0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        sb_q.delete();
        @(negedge clk);
    endtask

    initial begin
        int wc0;
        int n;
        reset     = 1'b1;
        start     = 1'b0;
        force_low = 1'b0;
        rom_clear();
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        reset = 1'b0;

        // Write, settle delay, write, end marker.
        rom_clear();
        rom_mem[0] = 16'h1280; rom_mem[1] = 16'hFFF0; rom_mem[2] = 16'h1214;
        push(16'h1280, -1);
        push(16'h1214, GAP_DELAY);
        wc0 = write_cnt;
        pulse_start();
        wait_done("basic_done", 200);
        check_eq("basic_busy", 32'(busy), 32'd0);
        check_eq("basic_writes", 32'(write_cnt - wc0), 32'd2);
        check_eq("basic_sb_empty", 32'(sb_q.size()), 32'd0);

        // Immediate end marker: done within 4 cycles, no writes.
        rom_clear();
        wc0 = write_cnt;
        @(negedge clk);
        start = 1'b1;
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            start = 1'b0;
            n++;
        end
        start = 1'b0;
        check_eq("ffff_latency", 32'(n <= 4), 32'd1);
        check_eq("ffff_done", 32'(done), 32'd1);
        check_eq("ffff_writes", 32'(write_cnt - wc0), 32'd0);

        // Master busy before the first write: start must wait for ready.
        rom_clear();
        rom_mem[0] = 16'h3A04;
        force_low  = 1'b1;
        wc0 = write_cnt;
        pulse_start();
        repeat (50) @(negedge clk);
        check_eq("hold_no_write", 32'(write_cnt - wc0), 32'd0);
        check_eq("hold_busy", 32'(busy), 32'd1);
        push(16'h3A04, 1);
        force_low = 1'b0;
        wait_done("hold_done", 200);
        check_eq("hold_writes", 32'(write_cnt - wc0), 32'd1);

        // Full ROM of writes: stops at the last address without wrapping.
        for (int i = 0; i < 256; i++) begin
            rom_mem[i] = {8'(i) ^ 8'h5A, 8'(i)};
            push(rom_mem[i], (i == 0) ? -1 : GAP_WRITE);
        end
        wc0 = write_cnt;
        pulse_start();
        wait_done("full_done", 9000);
        check_eq("full_addr", 32'(cfg.rom_addr), 32'd255);
        check_eq("full_writes", 32'(write_cnt - wc0), 32'd256);
        repeat (10) @(negedge clk);
        check_eq("full_addr_hold", 32'(cfg.rom_addr), 32'd255);
        check_eq("full_done_hold", 32'(done), 32'd1);
        check_eq("full_no_extra", 32'(write_cnt - wc0), 32'd256);

        // Reset while waiting for the SCCB transfer to finish, then replay.
        rom_clear();
        rom_mem[0] = 16'h1111; rom_mem[1] = 16'h2222;
        push(16'h1111, -1);
        wc0 = write_cnt;
        pulse_start();
        n = 0;
        while (write_cnt == wc0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        check_eq("rstxfer_ready_low", 32'(cfg.sccb_ready), 32'd0);
        apply_reset();
        check_reset_vals("rstxfer");
        reset = 1'b0;
        check_eq("rstxfer_writes", 32'(write_cnt - wc0), 32'd1);
        push(16'h1111, -1);
        push(16'h2222, GAP_WRITE);
        wc0 = write_cnt;
        pulse_start();
        wait_done("rstxfer_replay_done", 300);
        check_eq("rstxfer_replay_writes", 32'(write_cnt - wc0), 32'd2);

        // Reset in the middle of a settle delay, then replay.
        rom_clear();
        rom_mem[0] = 16'hFFF0; rom_mem[1] = 16'h3333;
        wc0 = write_cnt;
        pulse_start();
        repeat (3) @(negedge clk);
        check_eq("rstdly_busy", 32'(busy), 32'd1);
        apply_reset();
        check_reset_vals("rstdly");
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check_eq("rstdly_writes", 32'(write_cnt - wc0), 32'd0);
        push(16'h3333, -1);
        pulse_start();
        wait_done("rstdly_replay_done", 300);
        check_eq("rstdly_replay_writes", 32'(write_cnt - wc0), 32'd1);

        // Start while busy is ignored; start after done replays everything.
        rom_clear();
        rom_mem[0] = 16'h4444; rom_mem[1] = 16'h5555;
        push(16'h4444, -1);
        push(16'h5555, GAP_WRITE);
        wc0 = write_cnt;
        pulse_start();
        repeat (10) @(negedge clk);
        pulse_start();
        repeat (30) @(negedge clk);
        pulse_start();
        wait_done("restart_done", 300);
        check_eq("restart_writes", 32'(write_cnt - wc0), 32'd2);
        push(16'h4444, -1);
        push(16'h5555, GAP_WRITE);
        pulse_start();
        check_eq("replay_busy", 32'(busy), 32'd1);
        wait_done("replay_done", 300);
        check_eq("replay_writes", 32'(write_cnt - wc0), 32'd4);
        check_eq("replay_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
